keypad_bcd_entry: RTL
=====================

Name: keypad_bcd_entry

Overview:
Multi-digit PS/2 number-entry block, the parametrised successor to the single-key scan-code-to-BCD decoder. It consumes decoded key-press events ({extended flag, scan code}, 9 bits) and decodes digits with extended-flag awareness, optionally also from the top-row number keys. It accumulates digits into a DIGITS-wide BCD register with backspace, clear and enter editing, and commits the entered number with a one-cycle valid pulse. It sits between the PS/2 keyboard front end and the display and arithmetic logic.

Parameters:
DIGITS, 4, number of BCD digits held; legal range 1..8.
EN_TOPROW, 1, 1 = top-row digit codes are also accepted; 0 = keypad codes only.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
key_valid  input  1  one-cycle pulse: new make (press) event on last_change.
last_change  input  9  bit8 = E0 extended flag, [7:0] = scan code.
digits  output  4*DIGITS  BCD entry buffer; newest digit in [3:0].
count  output  4  digits currently entered, 0..DIGITS.
num_valid  output  1  one-cycle pulse on commit.
num_out  output  4*DIGITS  last committed number; held until the next commit.
overflow  output  1  sticky: a digit was dropped because the buffer was full.
state_o  output  2  current FSM state, for debug.

Behaviour:
- Reset (rst_n low, asynchronous): digits=0, count=0, num_valid=0, num_out=0, overflow=0, state=EMPTY(0).
- Events are evaluated only on key_valid=1. All outputs are registered. An event sampled at edge N is visible after edge N; num_valid is high for exactly that one cycle.
- Decode requires bit8=0 for digits. Extended codes with these scan codes are navigation keys and are ignored.
- Keypad digit codes: 0=70, 1=69, 2=72, 3=7A, 4=6B, 5=73, 6=74, 7=6C, 8=75, 9=7D.
- Top-row digit codes (EN_TOPROW=1 only): 0=45, 1=16, 2=1E, 3=26, 4=25, 5=2E, 6=36, 7=3D, 8=3E, 9=46.
- Commands:
  - BKSP = {0,66}.
  - ENTER = {0,5A} or {1,5A}.
  - CLEAR = {0,76} (ESC).
  - Any other code is ignored: no state change.
- FSM states: EMPTY(0), ENTRY(1), DONE(2). Encoding 3 is unused and recovers to EMPTY.
- DIGIT event:
  - count<DIGITS: digits <= {digits shifted left by 4, d}; count+1; state=ENTRY.
  - count==DIGITS: digit dropped; overflow<=1; no other change.
  - In DONE: the buffer is first treated as empty. Result: digits={0..,d}, count=1, overflow=0, state=ENTRY.
- BKSP event:
  - In ENTRY: digits shifted right by 4, zero-filled at the top; count-1; overflow<=0. If count becomes 0, state=EMPTY.
  - In EMPTY or DONE: ignored.
- ENTER event:
  - In ENTRY: num_out<=digits; num_valid pulse; state=DONE; overflow<=0. digits and count are held so the display keeps showing the value.
  - In EMPTY or DONE: ignored, no pulse.
- CLEAR event, any state: digits=0, count=0, overflow=0, state=EMPTY. num_out is unchanged.
- Leading zeros count as digits: "0","0","7" gives count=3, digits=0x007.
- key_valid high on consecutive cycles is legal; each cycle is one event.
- Reset asserted mid-entry discards everything immediately, including num_out.

Test Plan:
- Reset, then keypad 1,2,3,4 (69,72,7A,6B) -> digits=0x1234, count=4, state=ENTRY, no num_valid.
- Continue with keypad 5 (73) -> digits stays 0x1234, overflow=1. Then BKSP -> digits=0x0123, count=3, overflow=0.
- ENTER {1,5A} -> num_valid high for exactly 1 cycle, num_out=0x0123, state=DONE. Then keypad 9 (7D) -> digits=0x0009, count=1, num_out still 0x0123.
- Extended {1,70} and {1,69}, plus unknown code 0x1C -> no change to any output. With EN_TOPROW=0, top-row 16 ignored; with EN_TOPROW=1, 16 enters digit 1.
- ENTER and BKSP in EMPTY -> no pulse, count=0. CLEAR in ENTRY with count=3 -> digits=0, count=0, state=EMPTY.
- Back-to-back key_valid over 3 cycles with 72,72,5A -> num_valid on the third event's cycle, num_out=0x0022. Deassert rst_n mid-entry asynchronously -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/keypad_bcd_entry.sv
// Multi-digit PS/2 number entry: decodes make events into BCD digits and
// edits a DIGITS-wide entry buffer with backspace, clear and enter/commit.
module keypad_bcd_entry #(
  parameter int DIGITS    = 4,
  parameter bit EN_TOPROW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [8:0]            last_change,
  output logic [4*DIGITS-1:0]   digits,
  output logic [3:0]            count,
  output logic                  num_valid,
  output logic [4*DIGITS-1:0]   num_out,
  output logic                  overflow,
  output logic [1:0]            state_o
);

  localparam int         W      = 4 * DIGITS;
  localparam logic [3:0] MAXCNT = 4'(DIGITS);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2,
    S_BAD   = 2'd3
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_digits;
  logic [3:0]   r_count;
  logic         r_num_valid;
  logic [W-1:0] r_num_out;
  logic         r_overflow;

  state_t       w_state_next;
  logic [W-1:0] w_digits_next;
  logic [3:0]   w_count_next;
  logic         w_num_valid_next;
  logic [W-1:0] w_num_out_next;
  logic         w_overflow_next;

  logic         w_ext;
  logic [7:0]   w_code;
  logic         w_pad_hit;
  logic [3:0]   w_pad_digit;
  logic         w_top_hit;
  logic [3:0]   w_top_digit;
  logic         w_is_digit;
  logic [3:0]   w_digit;
  logic         w_is_bksp;
  logic         w_is_enter;
  logic         w_is_clear;

  assign w_ext  = last_change[8];
  assign w_code = last_change[7:0];

  // Extended codes sharing keypad scan codes are navigation keys, never digits.
  always_comb begin
    w_pad_hit   = 1'b1;
    w_pad_digit = 4'd0;
    case (w_code)
      8'h70: w_pad_digit = 4'd0;
      8'h69: w_pad_digit = 4'd1;
      8'h72: w_pad_digit = 4'd2;
      8'h7A: w_pad_digit = 4'd3;
      8'h6B: w_pad_digit = 4'd4;
      8'h73: w_pad_digit = 4'd5;
      8'h74: w_pad_digit = 4'd6;
      8'h6C: w_pad_digit = 4'd7;
      8'h75: w_pad_digit = 4'd8;
      8'h7D: w_pad_digit = 4'd9;
      default: w_pad_hit = 1'b0;
    endcase
  end

  generate
    if (EN_TOPROW) begin : g_toprow
      always_comb begin
        w_top_hit   = 1'b1;
        w_top_digit = 4'd0;
        case (w_code)
          8'h45: w_top_digit = 4'd0;
          8'h16: w_top_digit = 4'd1;
          8'h1E: w_top_digit = 4'd2;
          8'h26: w_top_digit = 4'd3;
          8'h25: w_top_digit = 4'd4;
          8'h2E: w_top_digit = 4'd5;
          8'h36: w_top_digit = 4'd6;
          8'h3D: w_top_digit = 4'd7;
          8'h3E: w_top_digit = 4'd8;
          8'h46: w_top_digit = 4'd9;
          default: w_top_hit = 1'b0;
        endcase
      end
    end else begin : g_no_toprow
      assign w_top_hit   = 1'b0;
      assign w_top_digit = 4'd0;
    end
  endgenerate

  assign w_is_digit = !w_ext && (w_pad_hit || w_top_hit);
  assign w_digit    = w_pad_hit ? w_pad_digit : w_top_digit;
  assign w_is_bksp  = !w_ext && (w_code == 8'h66);
  assign w_is_clear = !w_ext && (w_code == 8'h76);
  assign w_is_enter = (w_code == 8'h5A);

  always_comb begin
    w_state_next     = r_state;
    w_digits_next    = r_digits;
    w_count_next     = r_count;
    w_num_valid_next = 1'b0;
    w_num_out_next   = r_num_out;
    w_overflow_next  = r_overflow;
    if (r_state == S_BAD) begin
      w_state_next    = S_EMPTY;
      w_digits_next   = '0;
      w_count_next    = 4'd0;
      w_overflow_next = 1'b0;
    end else if (key_valid) begin
      if (w_is_clear) begin
        w_state_next    = S_EMPTY;
        w_digits_next   = '0;
        w_count_next    = 4'd0;
        w_overflow_next = 1'b0;
      end else if (w_is_digit) begin
        if (r_state == S_DONE) begin
          // A digit after a commit starts a fresh number.
          w_digits_next      = '0;
          w_digits_next[3:0] = w_digit;
          w_count_next       = 4'd1;
          w_overflow_next    = 1'b0;
          w_state_next       = S_ENTRY;
        end else if (r_count >= MAXCNT) begin
          w_overflow_next = 1'b1;
        end else begin
          w_digits_next      = r_digits << 4;
          w_digits_next[3:0] = w_digit;
          w_count_next       = r_count + 4'd1;
          w_state_next       = S_ENTRY;
        end
      end else if (w_is_bksp && (r_state == S_ENTRY)) begin
        w_digits_next   = r_digits >> 4;
        w_count_next    = r_count - 4'd1;
        w_overflow_next = 1'b0;
        if (r_count == 4'd1) begin
          w_state_next = S_EMPTY;
        end
      end else if (w_is_enter && (r_state == S_ENTRY)) begin
        w_num_out_next   = r_digits;
        w_num_valid_next = 1'b1;
        w_overflow_next  = 1'b0;
        w_state_next     = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_digits    <= '0;
      r_count     <= 4'd0;
      r_num_valid <= 1'b0;
      r_num_out   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_digits    <= w_digits_next;
      r_count     <= w_count_next;
      r_num_valid <= w_num_valid_next;
      r_num_out   <= w_num_out_next;
      r_overflow  <= w_overflow_next;
    end
  end

  assign digits    = r_digits;
  assign count     = r_count;
  assign num_valid = r_num_valid;
  assign num_out   = r_num_out;
  assign overflow  = r_overflow;
  assign state_o   = r_state;

endmodule
